// File: rtl/spi_loader_pkg.sv
// Shared definitions for the SPI memory loader: FSM state encoding,
// header field positions, default end-of-program marker and a byte swap helper.
package spi_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_e;

  localparam logic [31:0] DEFAULT_END_WORD = 32'h7F87_8000;

  // Header layout: target index in the top nibble, start address in the low bits.
  localparam int HDR_TGT_MSB = 31;
  localparam int HDR_TGT_LSB = 28;
  localparam int HDR_TGT_W   = HDR_TGT_MSB - HDR_TGT_LSB + 1;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_loader_fifo.sv
// Two-entry write FIFO. The head entry is always visible on data_o while
// valid_o is high. A push on a full FIFO is taken only when a pop happens in
// the same cycle; the caller is expected to flag overflow otherwise.
module spi_loader_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         pop_eff;
  logic         push_eff;

  // Qualify pop/push against occupancy so the storage can never be corrupted.
  always_comb begin
    pop_eff  = pop_i && (count_q != 2'd0);
    push_eff = push_i && ((count_q != 2'd2) || pop_eff);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_eff) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_eff) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head entry and status flags.
  always_comb begin
    data_o  = mem_q[rd_ptr_q];
    valid_o = (count_q != 2'd0);
    full_o  = (count_q == 2'd2);
  end

endmodule

// File: rtl/spi_mem_loader.sv
// SPI (mode 0) memory loader. Receives a header word (target + start address)
// followed by data words and an end marker, and issues word writes to one of
// NUM_TARGETS memories through a 2-entry FIFO.
// Write handshake: an entry is transferred on every clk_i cycle where
// wvalid_o and wready_i are both high; wvalid_o, once high, stays high with
// stable waddr_o/wdata_o/wsel_o until that transfer happens.
// Optional feature: define SPI_MEM_LOADER_CHECKSUM_EN to require a checksum
// word (32-bit modular sum of the data words) after the end marker.
module spi_mem_loader
  import spi_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 13,
  parameter int          NUM_TARGETS = 2,
  parameter logic [31:0] END_WORD    = DEFAULT_END_WORD,
  parameter int          BYTE_SWAP   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sck_i,
  input  logic                   sdi_i,
  input  logic                   csb_i,
  output logic                   sdo_o,
  output logic [ADDR_WIDTH-1:0]  waddr_o,
  output logic [31:0]            wdata_o,
  output logic [NUM_TARGETS-1:0] wsel_o,
  output logic                   wvalid_o,
  input  logic                   wready_i,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int FW = ADDR_WIDTH + 32 + NUM_TARGETS;

  loader_state_e          state_q, state_n;
  logic [1:0]             sck_s, sdi_s, csb_s;
  logic                   sck_d, csb_d;
  logic                   sck_rise, csb_fall, csb_rise;
  logic                   sample;
  logic [31:0]            shift_q, word_next;
  logic [4:0]             bit_cnt_q;
  logic                   word_done;
  logic [HDR_TGT_W-1:0]   hdr_tgt;
  logic                   tgt_bad;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [NUM_TARGETS-1:0] tgt_oh_q;
  logic                   push_req, overflow, fifo_push, pop, fifo_full;
  logic [31:0]            push_data;
  logic [FW-1:0]          fifo_head;
`ifdef SPI_MEM_LOADER_CHECKSUM_EN
  logic [31:0]            sum_q;
`endif

  // Two-flop synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_s <= '0;
      sdi_s <= '0;
      csb_s <= '0;
      sck_d <= 1'b0;
      csb_d <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], sck_i};
      sdi_s <= {sdi_s[0], sdi_i};
      csb_s <= {csb_s[0], csb_i};
      sck_d <= sck_s[1];
      csb_d <= csb_s[1];
    end
  end

  // Edge detection, word assembly and header decode.
  always_comb begin
    sck_rise  = sck_s[1] && !sck_d;
    csb_fall  = !csb_s[1] && csb_d;
    csb_rise  = csb_s[1] && !csb_d;
    word_next = {shift_q[30:0], sdi_s[1]};
    word_done = sample && (bit_cnt_q == 5'd31);
    hdr_tgt   = word_next[HDR_TGT_MSB:HDR_TGT_LSB];
    tgt_bad   = int'({28'd0, hdr_tgt}) >= NUM_TARGETS;
    push_data = (BYTE_SWAP != 0) ? byte_swap(word_next) : word_next;
    pop       = wvalid_o && wready_i;
    push_req  = (state_q == ST_DATA) && word_done && (word_next != END_WORD);
    overflow  = push_req && fifo_full && !pop;
    fifo_push = push_req && !overflow;
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // FSM next-state logic; a csb falling edge restarts from any state.
  always_comb begin
    state_n = state_q;
    if (csb_fall) begin
      state_n = ST_HEADER;
    end else begin
      case (state_q)
        ST_IDLE: state_n = ST_IDLE;
        ST_HEADER: begin
          if (csb_rise)       state_n = ST_IDLE;
          else if (word_done) state_n = tgt_bad ? ST_ERROR : ST_DATA;
        end
        ST_DATA: begin
          if (csb_rise) state_n = ST_IDLE;
          else if (word_done) begin
`ifdef SPI_MEM_LOADER_CHECKSUM_EN
            if (word_next == END_WORD) state_n = ST_CHECK;
`else
            if (word_next == END_WORD) state_n = ST_DONE;
`endif
            else if (overflow)         state_n = ST_ERROR;
          end
        end
`ifdef SPI_MEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (csb_rise)       state_n = ST_IDLE;
          else if (word_done) state_n = (word_next == sum_q) ? ST_DONE : ST_ERROR;
        end
`endif
        ST_DONE:  state_n = ST_DONE;
        ST_ERROR: state_n = ST_ERROR;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: sampling enable and sticky status flags.
  always_comb begin
    sample = (state_q == ST_HEADER || state_q == ST_DATA || state_q == ST_CHECK)
             && !csb_s[1] && sck_rise;
    done_o = (state_q == ST_DONE);
    err_o  = (state_q == ST_ERROR);
    sdo_o  = done_o && !err_o;
  end

  // Shift register, bit counter, write address, target select and checksum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      tgt_oh_q  <= '0;
`ifdef SPI_MEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else if (csb_fall || csb_rise) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef SPI_MEM_LOADER_CHECKSUM_EN
      if (csb_fall) sum_q <= '0;
`endif
    end else begin
      if (sample) begin
        shift_q   <= word_next;
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (state_q == ST_HEADER && word_done) begin
        addr_q   <= word_next[ADDR_WIDTH-1:0];
        tgt_oh_q <= NUM_TARGETS'(1) << hdr_tgt;
      end
      if (fifo_push) begin
        addr_q <= addr_q + 1'b1;
`ifdef SPI_MEM_LOADER_CHECKSUM_EN
        sum_q  <= sum_q + word_next;
`endif
      end
    end
  end

  spi_loader_fifo #(.W(FW)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (fifo_push),
    .data_i ({addr_q, push_data, tgt_oh_q}),
    .pop_i  (pop),
    .data_o (fifo_head),
    .valid_o(wvalid_o),
    .full_o (fifo_full)
  );

  assign {waddr_o, wdata_o, wsel_o} = fifo_head;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed bench for spi_mem_loader: table of complete frames plus
// hand-written sequences for backpressure overflow, aborted frames and reset.
module tb_spi_mem_loader;

  localparam int          AW   = 13;
  localparam int          NT   = 2;
  localparam logic [31:0] ENDW = 32'h7F87_8000;
  localparam int          WW   = AW + 32 + NT;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          sck_i = 1'b0;
  logic          sdi_i = 1'b0;
  logic          csb_i = 1'b1;
  logic          wready_i = 1'b1;
  logic          sdo_o, wvalid_o, done_o, err_o;
  logic [AW-1:0] waddr_o;
  logic [31:0]   wdata_o;
  logic [NT-1:0] wsel_o;

  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] cap_q[$];
  int            n_pass  = 0;
  int            n_total = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  spi_mem_loader #(
    .ADDR_WIDTH (AW),
    .NUM_TARGETS(NT),
    .END_WORD   (ENDW),
    .BYTE_SWAP  (1)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sck_i   (sck_i),
    .sdi_i   (sdi_i),
    .csb_i   (csb_i),
    .sdo_o   (sdo_o),
    .waddr_o (waddr_o),
    .wdata_o (wdata_o),
    .wsel_o  (wsel_o),
    .wvalid_o(wvalid_o),
    .wready_i(wready_i),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  // Capture accepted writes away from the active edge.
  always @(negedge clk_i) begin
    if (!rst_i && wvalid_o && wready_i) cap_q.push_back({waddr_o, wdata_o, wsel_o});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  // driver tasks
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) begin
      sdi_i = w[i];
      tick(4);
      sck_i = 1'b1;
      tick(4);
      sck_i = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] hdr, input int n,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] ck_adj);
    logic [31:0] sum;
    logic [31:0] w;
    sum = 32'd0;
    csb_i = 1'b0;
    tick(4);
    send_bits(hdr, 32);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      send_bits(w, 32);
      sum = sum + w;
    end
    send_bits(ENDW, 32);
`ifdef SPI_MEM_LOADER_CHECKSUM_EN
    send_bits(sum + ck_adj, 32);
`else
    if (ck_adj != 32'd0) sum = sum + ck_adj;
`endif
    tick(8);
    csb_i = 1'b1;
    tick(8);
  endtask

  // scoreboard compare of captured writes against the expected queue
  task automatic check_writes(input string name);
    int n;
    check({name, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_wr%0d", name, i), 64'(cap_q[i]), 64'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    string         name;
    logic [31:0]   hdr;
    int            n_data;
    logic [31:0]   d0, d1, d2;
    int            n_wr;
    logic [AW-1:0] a0, a1;
    logic [31:0]   wd0, wd1;
    logic [NT-1:0] sel;
    logic          done;
    logic          err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"basic",  32'h0000_0010, 2, 32'h1122_3344, 32'hAABB_CCDD, 32'h0,
                2, 13'h0010, 13'h0011, 32'h4433_2211, 32'hDDCC_BBAA, 2'b01, 1'b1, 1'b0};
    vecs[1] = '{"wrap",   32'h1000_1FFF, 2, 32'h0000_0001, 32'h8000_0000, 32'h0,
                2, 13'h1FFF, 13'h0000, 32'h0100_0000, 32'h0000_0080, 2'b10, 1'b1, 1'b0};
    vecs[2] = '{"badtgt", 32'h3000_0000, 1, 32'h1234_5678, 32'h0, 32'h0,
                0, 13'h0, 13'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1};
    vecs[3] = '{"single", 32'h0000_0005, 1, 32'hDEAD_BEEF, 32'h0, 32'h0,
                1, 13'h0005, 13'h0, 32'hEFBE_ADDE, 32'h0, 2'b01, 1'b1, 1'b0};

    // reset state
    tick(5);
    check("rst_wvalid", 64'(wvalid_o), 64'd0);
    check("rst_flags", 64'({done_o, err_o, sdo_o}), 64'd0);
    check("rst_waddr", 64'(waddr_o), 64'd0);
    check("rst_wdata", 64'(wdata_o), 64'd0);
    check("rst_wsel", 64'(wsel_o), 64'd0);
    rst_i = 1'b0;
    tick(4);

    // table-driven frames with wready held high
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].n_wr > 0) exp_q.push_back({vecs[v].a0, vecs[v].wd0, vecs[v].sel});
      if (vecs[v].n_wr > 1) exp_q.push_back({vecs[v].a1, vecs[v].wd1, vecs[v].sel});
      send_frame(vecs[v].hdr, vecs[v].n_data, vecs[v].d0, vecs[v].d1, vecs[v].d2, 32'd0);
      check_writes(vecs[v].name);
      check({vecs[v].name, "_done"}, 64'(done_o), 64'(vecs[v].done));
      check({vecs[v].name, "_err"}, 64'(err_o), 64'(vecs[v].err));
      check({vecs[v].name, "_sdo"}, 64'(sdo_o), 64'(vecs[v].done && !vecs[v].err));
    end

    // backpressure: two words queue, third overflows
    wready_i = 1'b0;
    csb_i = 1'b0;
    tick(4);
    check("bp_flags_cleared", 64'({done_o, err_o}), 64'd0);
    send_bits(32'h0000_0100, 32);
    check("bp_wvalid_empty", 64'(wvalid_o), 64'd0);
    send_bits(32'hA0A1_A2A3, 32);
    check("bp_wvalid_first", 64'(wvalid_o), 64'd1);
    check("bp_head_addr", 64'(waddr_o), 64'h100);
    send_bits(32'hB0B1_B2B3, 32);
    check("bp_err_two", 64'(err_o), 64'd0);
    send_bits(32'hC0C1_C2C3, 32);
    check("bp_err_three", 64'(err_o), 64'd1);
    check("bp_sdo", 64'(sdo_o), 64'd0);
    wready_i = 1'b1;
    tick(4);
    check("bp_drained", 64'(wvalid_o), 64'd0);
    csb_i = 1'b1;
    tick(8);
    exp_q.push_back({13'h0100, 32'hA3A2_A1A0, 2'b01});
    exp_q.push_back({13'h0101, 32'hB3B2_B1B0, 2'b01});
    check_writes("bp");
    check("bp_err_sticky", 64'(err_o), 64'd1);

    // aborted frame: csb rises after 20 bits of a data word
    csb_i = 1'b0;
    tick(4);
    check("abort_err_cleared", 64'(err_o), 64'd0);
    send_bits(32'h0000_0020, 32);
    send_bits(32'hFFFF_FFFF, 20);
    csb_i = 1'b1;
    tick(8);
    check("abort_flags", 64'({done_o, err_o}), 64'd0);
    check_writes("abort");
    exp_q.push_back({13'h0030, 32'h0403_0201, 2'b01});
    send_frame(32'h0000_0030, 1, 32'h0102_0304, 32'h0, 32'h0, 32'd0);
    check_writes("after_abort");
    check("after_abort_done", 64'(done_o), 64'd1);

    // reset in the middle of a load: no writes until a new csb falling edge
    csb_i = 1'b0;
    tick(4);
    send_bits(32'h0000_0040, 32);
    send_bits(32'h1111_1111, 16);
    rst_i = 1'b1;
    tick(2);
    check("midrst_outputs", 64'({wvalid_o, done_o, err_o, sdo_o}), 64'd0);
    check("midrst_wsel", 64'(wsel_o), 64'd0);
    rst_i = 1'b0;
    send_bits(32'h0000_1111, 16);
    send_bits(32'h2222_2222, 32);
    send_bits(ENDW, 32);
    tick(8);
    csb_i = 1'b1;
    tick(8);
    check_writes("midrst");
    check("midrst_done", 64'(done_o), 64'd0);

`ifdef SPI_MEM_LOADER_CHECKSUM_EN
    exp_q.push_back({13'h0000, 32'h0100_0000, 2'b01});
    exp_q.push_back({13'h0001, 32'h0200_0000, 2'b01});
    send_frame(32'h0000_0000, 2, 32'd1, 32'd2, 32'd0, 32'd0);
    check_writes("ck_good");
    check("ck_good_done", 64'(done_o), 64'd1);
    exp_q.push_back({13'h0000, 32'h0100_0000, 2'b01});
    exp_q.push_back({13'h0001, 32'h0200_0000, 2'b01});
    send_frame(32'h0000_0000, 2, 32'd1, 32'd2, 32'd0, 32'd1);
    check_writes("ck_bad");
    check("ck_bad_err", 64'(err_o), 64'd1);
`endif

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_mem_loader.md
SPI_MEM_LOADER -- requirements
Module: spi_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13: word-address width of each target memory.
REQ-002 SHALL have parameter NUM_TARGETS, default 2: number of target memories (ICCM, DCCM, ...), range 1..16.
REQ-003 SHALL have parameter END_WORD, default 32'h7F87_8000: end-of-program marker.
REQ-004 SHALL have parameter BYTE_SWAP, default 1: when 1, byte order of data words is reversed before output.
REQ-005 SHALL have port clk_i  in  1  system clock; all logic in this single domain.
REQ-006 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports sck_i, sdi_i, csb_i  in  1 each  SPI clock, data and chip-select (active-low), asynchronous to clk_i.
REQ-008 SHALL have port sdo_o  out  1  status: high when done_o is high and err_o is low.
REQ-009 SHALL have port waddr_o  out  ADDR_WIDTH  write word address.
REQ-010 SHALL have port wdata_o  out  32  write data.
REQ-011 SHALL have port wsel_o  out  NUM_TARGETS  one-hot target select, valid with wvalid_o.
REQ-012 SHALL have ports wvalid_o (out 1) and wready_i (in 1)  write handshake.
REQ-013 SHALL have ports done_o and err_o  out  1 each  sticky load-complete and load-error flags.

Function
REQ-014 SHALL pass sck_i, sdi_i and csb_i through 2-flop synchronizers and sample sdi on each detected synchronized sck rising edge (SPI mode 0) while synchronized csb is low.
REQ-015 SHALL shift bits MSB-first into a 32-bit register; a word completes on the 32nd sampled bit.
REQ-016 SHALL implement FSM IDLE -> HEADER on csb falling edge; HEADER -> DATA on the completed header word; DATA -> DONE on a completed word equal to END_WORD; any state -> ERROR on a fault.
REQ-017 SHALL decode the header as: bits [31:28] target index, bits [ADDR_WIDTH-1:0] start word address; all other bits ignored.
REQ-018 SHALL enter ERROR when the target index is >= NUM_TARGETS.
REQ-019 SHALL push each completed non-END data word, with the current address and target, into a 2-entry FIFO, then increment the address modulo 2^ADDR_WIDTH (wrap silently).
REQ-020 SHALL present the FIFO head on waddr_o/wdata_o/wsel_o with wvalid_o high whenever the FIFO is non-empty; an entry pops on the cycle wvalid_o and wready_i are both high.
REQ-021 SHALL assert wvalid_o on the clk_i cycle after the word-completing sample when the FIFO was empty (latency 1 clk from the synchronized edge).
REQ-022 SHALL enter ERROR (overflow) when a word completes while the FIFO is full and no pop occurs that cycle; when a pop and a push coincide on a full FIFO, it SHALL accept both.
REQ-023 SHALL discard a partial word and return to IDLE when csb rises in HEADER or DATA; already-queued FIFO entries still drain.
REQ-024 SHALL set done_o on entering DONE and err_o on entering ERROR; both stay set until the next csb falling edge, which clears them and restarts at HEADER.
REQ-025 SHALL ignore sck edges in DONE and ERROR.
REQ-026 SHALL hold wvalid_o low whenever the FIFO is empty, independent of FSM state.

Reset
REQ-027 SHALL, while rst_i is high, clear the FSM to IDLE, the FIFO to empty, the shift register, bit count, address and synchronizers to 0, and hold all outputs low (wvalid_o, done_o, err_o, sdo_o, waddr_o, wdata_o, wsel_o = 0).
REQ-028 SHALL abort any load in progress on reset, with no further write issued until a new csb falling edge occurs after reset release.

Configuration
REQ-029 SHALL, with SPI_MEM_LOADER_CHECKSUM_EN defined, treat the word after END_WORD as a checksum and enter DONE only if it equals the 32-bit modular sum of all data words; otherwise enter ERROR.
REQ-030 SHALL, without SPI_MEM_LOADER_CHECKSUM_EN, enter DONE directly on END_WORD and compile no checksum logic.

Structure
REQ-031 SHALL take the FSM state enum, the header field positions and the default END_WORD from shared package spi_loader_pkg.
REQ-032 SHALL implement the 2-entry FIFO as sub-module spi_loader_fifo.

Verification
REQ-033 Header 0x0000_0010, data 0x1122_3344, 0xAABB_CCDD, then END_WORD, wready_i=1 -> writes at addresses 0x10 and 0x11 on target 0 with wdata 0x4433_2211 and 0xDDCC_BBAA; done_o=1 and sdo_o=1.
REQ-034 Header 0x1000_1FFF, two data words -> wsel_o=2'b10, addresses 0x1FFF then 0x0000.
REQ-035 Header 0x3000_0000 with NUM_TARGETS=2 -> err_o=1, sdo_o=0, no wvalid_o.
REQ-036 wready_i held low across 3 data words -> 2 entries queued, err_o=1 on the third word.
REQ-037 csb raised after 20 bits of a data word, then a new frame -> partial word dropped, flags cleared, new header accepted.
REQ-038 With checksum enabled, data 1, 2, END_WORD, checksum 3 -> done_o=1; checksum 4 -> err_o=1.
